sa_buf_ctrl: RTL and testbench

Sequencing controller for one subaddress receive buffer in the MKIO remote-terminal path. Accepts a received command (word count) and the decoded data-word stream from the 1553 decoder, and writes the words sequentially into the dual-port subaddress RAM. Publishes a completed message to the host and locks the buffer until the host releases it. Serves host reads through the RAM read port with fixed latency. Placed between the protocol decoder/host interface and the subaddress RAM; both RAM ports are driven from this block's single clock.

---
 rtl/sa_buf_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_sa_buf_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_buf_ctrl.sv
// sa_buf_ctrl - receive-buffer sequencer for one MKIO remote-terminal subaddress.
//
// Takes a receive command (expected word count) and the decoded data-word
// stream, writes the words sequentially into the dual-port subaddress RAM,
// and publishes a complete message to the host. The buffer then stays locked
// until the host releases it. Host reads go through the RAM read port with a
// fixed two-cycle request-to-valid latency.
//
// Ports:
//   clk_i-domain: clk (RAM wrclock/rdclock), rst_n (async, active low)
//   rx_cmd_valid, rx_wc             receive command; rx_wc==0 means full depth
//   rx_word_valid, rx_word          decoded data-word stream
//   rx_eom, rx_err                  end of message / decoder error strobes
//   host_rd_req, host_rd_idx        host read request
//   host_rd_valid, host_rd_data     host read response (data = mem_q)
//   host_release                    host has consumed the held message
//   msg_ready, msg_len              held-message status
//   err_wc, err_abort, err_busy     single-cycle registered error pulses
//   mem_data, mem_wraddress, mem_wren, mem_rdaddress, mem_q   RAM ports
module sa_buf_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_cmd_valid,
  input  logic [ADDR_WIDTH-1:0] rx_wc,
  input  logic                  rx_word_valid,
  input  logic [DATA_WIDTH-1:0] rx_word,
  input  logic                  rx_eom,
  input  logic                  rx_err,
  input  logic                  host_rd_req,
  input  logic [ADDR_WIDTH-1:0] host_rd_idx,
  output logic                  host_rd_valid,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  input  logic                  host_release,
  output logic                  msg_ready,
  output logic [ADDR_WIDTH:0]   msg_len,
  output logic                  err_wc,
  output logic                  err_abort,
  output logic                  err_busy,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_wraddress,
  output logic                  mem_wren,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, RECV, READY} state_e;

  localparam logic [ADDR_WIDTH:0] FULL_WC = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   exp_q, exp_d;
  logic                  ovf_q, ovf_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  err_wc_q, err_wc_d;
  logic                  err_abort_q, err_abort_d;
  logic                  err_busy_q, err_busy_d;
  logic                  rd_stage_q, rd_stage_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rdaddr_q, rdaddr_d;

  logic                  word_ok;
  logic [ADDR_WIDTH:0]   cnt_eff;
  logic                  ovf_eff;
  logic                  load;
  logic [ADDR_WIDTH:0]   cmd_exp;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    ovf_d       = ovf_q;
    wren_d      = 1'b0;
    wraddr_d    = wraddr_q;
    wdata_d     = wdata_q;
    ready_d     = ready_q;
    len_d       = len_q;
    err_wc_d    = 1'b0;
    err_abort_d = 1'b0;
    err_busy_d  = 1'b0;
    load        = 1'b0;

    cmd_exp = (rx_wc == '0) ? FULL_WC : {1'b0, rx_wc};
    word_ok = rx_word_valid && (cnt_q < exp_q);
    // eom judges the count including a word arriving in the same cycle
    cnt_eff = word_ok ? cnt_q + 1'b1 : cnt_q;
    ovf_eff = ovf_q | (rx_word_valid & ~word_ok);

    unique case (state_q)
      IDLE: begin
        if (rx_cmd_valid) load = 1'b1;
      end
      RECV: begin
        if (word_ok) begin
          wren_d   = 1'b1;
          wraddr_d = ptr_q;
          wdata_d  = rx_word;
          ptr_d    = ptr_q + 1'b1;
        end
        cnt_d = cnt_eff;
        ovf_d = ovf_eff;
        // superseding command beats error, error beats eom
        if (rx_cmd_valid) begin
          err_abort_d = 1'b1;
          load        = 1'b1;
        end else if (rx_err) begin
          err_abort_d = 1'b1;
          state_d     = IDLE;
        end else if (rx_eom) begin
          if (cnt_eff == exp_q && !ovf_eff) begin
            ready_d = 1'b1;
            len_d   = cnt_eff;
            state_d = READY;
          end else begin
            err_wc_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      READY: begin
        if (host_release) begin
          ready_d = 1'b0;
          len_d   = '0;
          state_d = IDLE;
          if (rx_cmd_valid) load = 1'b1;
        end else if (rx_cmd_valid) begin
          err_busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      exp_d   = cmd_exp;
      ptr_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = RECV;
    end

    rd_stage_d = host_rd_req & ready_q;
    rdaddr_d   = rd_stage_d ? host_rd_idx : rdaddr_q;
    rd_valid_d = rd_stage_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      ovf_q       <= 1'b0;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      len_q       <= '0;
      err_wc_q    <= 1'b0;
      err_abort_q <= 1'b0;
      err_busy_q  <= 1'b0;
      rd_stage_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rdaddr_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      ovf_q       <= ovf_d;
      wren_q      <= wren_d;
      wraddr_q    <= wraddr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      len_q       <= len_d;
      err_wc_q    <= err_wc_d;
      err_abort_q <= err_abort_d;
      err_busy_q  <= err_busy_d;
      rd_stage_q  <= rd_stage_d;
      rd_valid_q  <= rd_valid_d;
      rdaddr_q    <= rdaddr_d;
    end
  end

  assign mem_wren      = wren_q;
  assign mem_wraddress = wraddr_q;
  assign mem_data      = wdata_q;
  assign mem_rdaddress = rdaddr_q;
  assign msg_ready     = ready_q;
  assign msg_len       = len_q;
  assign err_wc        = err_wc_q;
  assign err_abort     = err_abort_q;
  assign err_busy      = err_busy_q;
  assign host_rd_valid = rd_valid_q;
  assign host_rd_data  = mem_q;

endmodule

// File: tb/tb_sa_buf_ctrl.sv
// Directed bench for sa_buf_ctrl with a behavioural 1-cycle-latency RAM.
module tb_sa_buf_ctrl;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_cmd_valid, rx_word_valid, rx_eom, rx_err;
  logic [AW-1:0] rx_wc;
  logic [DW-1:0] rx_word;
  logic          host_rd_req, host_release;
  logic [AW-1:0] host_rd_idx;
  logic          host_rd_valid;
  logic [DW-1:0] host_rd_data;
  logic          msg_ready;
  logic [AW:0]   msg_len;
  logic          err_wc, err_abort, err_busy;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] mem_wraddress, mem_rdaddress;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  sa_buf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_cmd_valid(rx_cmd_valid), .rx_wc(rx_wc),
    .rx_word_valid(rx_word_valid), .rx_word(rx_word),
    .rx_eom(rx_eom), .rx_err(rx_err),
    .host_rd_req(host_rd_req), .host_rd_idx(host_rd_idx),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
    .host_release(host_release),
    .msg_ready(msg_ready), .msg_len(msg_len),
    .err_wc(err_wc), .err_abort(err_abort), .err_busy(err_busy),
    .mem_data(mem_data), .mem_wraddress(mem_wraddress), .mem_wren(mem_wren),
    .mem_rdaddress(mem_rdaddress), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_wraddress] <= mem_data;
    mem_q <= ram[mem_rdaddress];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rx_cmd_valid  = 1'b0;
    rx_word_valid = 1'b0;
    rx_eom        = 1'b0;
    rx_err        = 1'b0;
    host_rd_req   = 1'b0;
    host_release  = 1'b0;
  endtask

  task automatic cmd(input logic [AW-1:0] wc);
    rx_cmd_valid = 1'b1;
    rx_wc        = wc;
    step();
    clr();
  endtask

  task automatic word(input logic [DW-1:0] w, input logic [AW-1:0] addr);
    rx_word_valid = 1'b1;
    rx_word       = w;
    step();
    check("wr_en", {31'd0, mem_wren}, 32'd1);
    check("wr_addr", {27'd0, mem_wraddress}, {27'd0, addr});
    check("wr_data", {16'd0, mem_data}, {16'd0, w});
    clr();
  endtask

  task automatic eom_ok(input logic [AW:0] len);
    rx_eom = 1'b1;
    step();
    clr();
    check("eom_ready", {31'd0, msg_ready}, 32'd1);
    check("eom_len", {26'd0, msg_len}, {26'd0, len});
    check("eom_err_wc", {31'd0, err_wc}, 32'd0);
  endtask

  task automatic release_buf();
    host_release = 1'b1;
    step();
    clr();
    check("rel_ready", {31'd0, msg_ready}, 32'd0);
    check("rel_len", {26'd0, msg_len}, 32'd0);
  endtask

  task automatic read_one(input logic [AW-1:0] idx, input logic [DW-1:0] exp);
    host_rd_req = 1'b1;
    host_rd_idx = idx;
    step();
    clr();
    check("rd_lat1", {31'd0, host_rd_valid}, 32'd0);
    step();
    check("rd_valid", {31'd0, host_rd_valid}, 32'd1);
    check("rd_data", {16'd0, host_rd_data}, {16'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    rx_wc = '0; rx_word = '0; host_rd_idx = '0;
    step(); step();
    check("rst_ready", {31'd0, msg_ready}, 32'd0);
    check("rst_len", {26'd0, msg_len}, 32'd0);
    check("rst_wren", {31'd0, mem_wren}, 32'd0);
    check("rst_errs", {29'd0, err_wc, err_abort, err_busy}, 32'd0);
    check("rst_rdv", {31'd0, host_rd_valid}, 32'd0);
    check("rst_rdaddr", {27'd0, mem_rdaddress}, 32'd0);
    rst_n = 1'b1;
    step();

    // 3-word message, then pipelined reads
    cmd(5'd3);
    for (int i = 0; i < 3; i++) word(16'hA001 + DW'(i), AW'(i));
    eom_ok(6'd3);
    check("eom_no_wren", {31'd0, mem_wren}, 32'd0);
    host_rd_req = 1'b1; host_rd_idx = 5'd0;
    step();
    check("pipe_lat", {31'd0, host_rd_valid}, 32'd0);
    host_rd_idx = 5'd1;
    step();
    check("pipe_v0", {31'd0, host_rd_valid}, 32'd1);
    check("pipe_d0", {16'd0, host_rd_data}, 32'h0000A001);
    host_rd_idx = 5'd2;
    step();
    check("pipe_v1", {31'd0, host_rd_valid}, 32'd1);
    check("pipe_d1", {16'd0, host_rd_data}, 32'h0000A002);
    clr();
    step();
    check("pipe_v2", {31'd0, host_rd_valid}, 32'd1);
    check("pipe_d2", {16'd0, host_rd_data}, 32'h0000A003);
    step();
    check("pipe_end", {31'd0, host_rd_valid}, 32'd0);
    release_buf();

    // read while not ready is ignored
    host_rd_req = 1'b1; host_rd_idx = 5'd0;
    step(); clr(); step();
    check("rd_ignored", {31'd0, host_rd_valid}, 32'd0);

    // full-depth message (wc=0 -> 32)
    cmd(5'd0);
    for (int i = 0; i < 32; i++) word(DW'(i), AW'(i));
    eom_ok(6'd32);
    read_one(5'd31, 16'h001F);
    release_buf();

    // overflow: 3 words into wc=2
    cmd(5'd2);
    word(16'hB000, 5'd0);
    word(16'hB001, 5'd1);
    rx_word_valid = 1'b1; rx_word = 16'hB002;
    step(); clr();
    check("ovf_no_wren", {31'd0, mem_wren}, 32'd0);
    rx_eom = 1'b1;
    step(); clr();
    check("ovf_err_wc", {31'd0, err_wc}, 32'd1);
    check("ovf_ready", {31'd0, msg_ready}, 32'd0);
    step();
    check("ovf_pulse", {31'd0, err_wc}, 32'd0);

    // underflow: 1 word into wc=2
    cmd(5'd2);
    word(16'hB100, 5'd0);
    rx_eom = 1'b1;
    step(); clr();
    check("unf_err_wc", {31'd0, err_wc}, 32'd1);
    check("unf_ready", {31'd0, msg_ready}, 32'd0);

    // abort by rx_err, later eom/word ignored
    cmd(5'd4);
    word(16'hC000, 5'd0);
    word(16'hC001, 5'd1);
    rx_err = 1'b1;
    step(); clr();
    check("abort_pulse", {31'd0, err_abort}, 32'd1);
    step();
    check("abort_clear", {31'd0, err_abort}, 32'd0);
    rx_eom = 1'b1; rx_word_valid = 1'b1;
    step(); clr();
    check("idle_eom_ready", {31'd0, msg_ready}, 32'd0);
    check("idle_eom_errwc", {31'd0, err_wc}, 32'd0);
    check("idle_word_wren", {31'd0, mem_wren}, 32'd0);

    // rx_err beats eom; same-cycle word still written
    cmd(5'd1);
    rx_word_valid = 1'b1; rx_word = 16'hE0E0; rx_eom = 1'b1; rx_err = 1'b1;
    step(); clr();
    check("errpri_wren", {31'd0, mem_wren}, 32'd1);
    check("errpri_abort", {31'd0, err_abort}, 32'd1);
    check("errpri_errwc", {31'd0, err_wc}, 32'd0);
    check("errpri_ready", {31'd0, msg_ready}, 32'd0);

    // busy rejection while message held
    cmd(5'd1);
    word(16'hC0DE, 5'd0);
    eom_ok(6'd1);
    cmd(5'd2);
    check("busy_pulse", {31'd0, err_busy}, 32'd1);
    check("busy_ready", {31'd0, msg_ready}, 32'd1);
    step();
    check("busy_clear", {31'd0, err_busy}, 32'd0);
    rx_word_valid = 1'b1; rx_word = 16'hDEAD;
    step(); clr();
    check("busy_no_wren", {31'd0, mem_wren}, 32'd0);
    read_one(5'd0, 16'hC0DE);

    // same-cycle release + command is accepted
    host_release = 1'b1; rx_cmd_valid = 1'b1; rx_wc = 5'd2;
    step(); clr();
    check("relcmd_busy", {31'd0, err_busy}, 32'd0);
    check("relcmd_ready", {31'd0, msg_ready}, 32'd0);
    word(16'h1111, 5'd0);
    word(16'h2222, 5'd1);
    eom_ok(6'd2);
    read_one(5'd1, 16'h2222);
    release_buf();

    // superseding command, then last word together with eom
    cmd(5'd3);
    word(16'h4444, 5'd0);
    cmd(5'd2);
    check("super_abort", {31'd0, err_abort}, 32'd1);
    word(16'h5A5A, 5'd0);
    rx_word_valid = 1'b1; rx_word = 16'h5B5B; rx_eom = 1'b1;
    step(); clr();
    check("sameeom_wren", {31'd0, mem_wren}, 32'd1);
    check("sameeom_addr", {27'd0, mem_wraddress}, 32'd1);
    check("sameeom_ready", {31'd0, msg_ready}, 32'd1);
    check("sameeom_len", {26'd0, msg_len}, 32'd2);
    release_buf();

    // async reset mid-message
    cmd(5'd4);
    word(16'h6000, 5'd0);
    word(16'h6001, 5'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wren", {31'd0, mem_wren}, 32'd0);
    check("arst_addr", {27'd0, mem_wraddress}, 32'd0);
    check("arst_data", {16'd0, mem_data}, 32'd0);
    check("arst_errs", {29'd0, err_wc, err_abort, err_busy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    cmd(5'd1);
    word(16'h7777, 5'd0);
    eom_ok(6'd1);
    read_one(5'd0, 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
